rvfi_harness_seq: RTL and testbench

- Parametrised sequencer for formal and simulation harnesses around an RVFI-instrumented core.
- Generates core reset release and a checker-enable pulse at a configurable depth.
- Counts retirements across NRET channels.
- Flags environment-constraint violations per channel as observable signals instead of hard-coded per-channel constraints.
- Sits between the harness clock/reset and the core wrapper plus insn/consistency checkers; replaces the fixed 2-channel inline sequencing.

---
 rtl/rvfi_harness_seq.sv | 84 ++++++++
 tb/tb_rvfi_harness_seq.sv | 127 ++++++++++++
 2 files changed

// File: rtl/rvfi_harness_seq.sv
// rvfi_harness_seq: reset/check sequencer, retire counter and env monitor; RVFI_HARNESS_NO_SYSTEM_EN enables per-channel constraints
module rvfi_harness_seq #(
  parameter int NRET         = 2,
  parameter int ILEN         = 32,
  parameter int RESET_CYCLES = 5,
  parameter int BMC_DEPTH    = 20,
  parameter int CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [NRET*ILEN-1:0] rvfi_insn,
  input  logic [NRET-1:0]      rvfi_trap,
  input  logic [NRET-1:0]      rvfi_halt,
  input  logic [NRET-1:0]      rvfi_intr,
  output logic                 core_reset,
  output logic                 check_enable,
  output logic [1:0]           phase,
  output logic [CNT_W-1:0]     cycle,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic [NRET-1:0]      env_ok,
  output logic                 env_fail
);
  localparam logic [1:0] RESET = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  if (!(RESET_CYCLES < BMC_DEPTH && BMC_DEPTH < (2 ** CNT_W) - 1)) begin : g_bad_depth
    $error("rvfi_harness_seq: BMC_DEPTH must satisfy RESET_CYCLES < BMC_DEPTH < 2**CNT_W-1");
  end
  logic [CNT_W-1:0] cycle_q, cycle_d, retire_q, retire_d;
  logic             core_reset_q, core_reset_d, check_q, check_d, env_fail_q, env_fail_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W:0]   sum;
`ifdef RVFI_HARNESS_NO_SYSTEM_EN
  // a valid channel must not trap, halt, take an interrupt, use SYSTEM, or be compressed
  always_comb begin
    env_ok = '1;
    for (int k = 0; k < NRET; k++)
      env_ok[k] = !rvfi_valid[k] || (!rvfi_trap[k] && !rvfi_halt[k] && !rvfi_intr[k] &&
                  rvfi_insn[k*ILEN +: 7] != 7'b1110011 && rvfi_insn[k*ILEN +: 2] == 2'b11);
  end
`else
  logic unused_env;
  assign unused_env = ^{rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr};
  assign env_ok = '1;
`endif
  // next-state: saturating counters, reset/check timing, phase FSM, sticky env failure
  always_comb begin
    cycle_d      = &cycle_q ? cycle_q : cycle_q + CNT_W'(1);
    core_reset_d = int'(cycle_q) + 1 < RESET_CYCLES;
    check_d      = cycle_q == CNT_W'(BMC_DEPTH);
    phase_d      = phase_q == RESET ? (core_reset_d ? RESET : RUN) :
                   phase_q == RUN   ? (check_d ? CHECK : RUN) : DONE;
    sum          = {1'b0, retire_q};
    for (int k = 0; k < NRET; k++) sum = sum + (CNT_W+1)'(rvfi_valid[k]);
    retire_d     = core_reset_q ? retire_q : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    env_fail_d   = env_fail_q || ((phase_q == RUN || phase_q == CHECK) && !(&env_ok));
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q      <= '0;
      core_reset_q <= 1'b1;
      check_q      <= 1'b0;
      phase_q      <= RESET;
      retire_q     <= '0;
      env_fail_q   <= 1'b0;
    end else begin
      cycle_q      <= cycle_d;
      core_reset_q <= core_reset_d;
      check_q      <= check_d;
      phase_q      <= phase_d;
      retire_q     <= retire_d;
      env_fail_q   <= env_fail_d;
    end
  end
  assign cycle        = cycle_q;
  assign core_reset   = core_reset_q;
  assign check_enable = check_q;
  assign phase        = phase_q;
  assign retire_cnt   = retire_q;
  assign env_fail     = env_fail_q;
endmodule

// File: tb/tb_rvfi_harness_seq.sv
// tb_rvfi_harness_seq: directed checks of sequencing, retire counting and env monitoring
module tb_rvfi_harness_seq;
`ifdef RVFI_HARNESS_NO_SYSTEM_EN
  localparam bit SYS = 1'b1;
`else
  localparam bit SYS = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h00000013;
  logic        clk = 1'b0, reset = 1'b1;
  logic [1:0]  rvfi_valid = '0, rvfi_trap = '0, rvfi_halt = '0, rvfi_intr = '0;
  logic [63:0] rvfi_insn = {NOP, NOP};
  logic        core_reset, check_enable, env_fail;
  logic [1:0]  phase, env_ok;
  logic [7:0]  cycle, retire_cnt;
  int total = 0, bad = 0;
  rvfi_harness_seq dut (
    .clk(clk), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .core_reset(core_reset), .check_enable(check_enable), .phase(phase),
    .cycle(cycle), .retire_cnt(retire_cnt), .env_ok(env_ok), .env_fail(env_fail)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_cycle"}, 32'(cycle), 0);
    chk({tag, "_core_reset"}, 32'(core_reset), 1);
    chk({tag, "_check_en"}, 32'(check_enable), 0);
    chk({tag, "_phase"}, 32'(phase), 0);
    chk({tag, "_retire"}, 32'(retire_cnt), 0);
    chk({tag, "_env_fail"}, 32'(env_fail), 0);
  endtask
  initial begin
    tick(3);
    chk_reset("rst");
    reset = 1'b0;
    tick(3);
    rvfi_valid = 2'b01; rvfi_trap = 2'b01;
    #1;
    chk("c3_env_ok_trap", 32'(env_ok), SYS ? 2'b10 : 2'b11);
    tick(1);
    chk("c4_cycle", 32'(cycle), 4);
    chk("c4_core_reset", 32'(core_reset), 1);
    chk("c4_phase", 32'(phase), 0);
    chk("c4_retire", 32'(retire_cnt), 0);
    chk("c4_env_fail", 32'(env_fail), 0);
    rvfi_valid = 2'b11; rvfi_trap = 2'b00;
    tick(1);
    chk("c5_core_reset", 32'(core_reset), 0);
    chk("c5_phase", 32'(phase), 1);
    chk("c5_retire", 32'(retire_cnt), 0);
    tick(1);
    chk("c6_retire", 32'(retire_cnt), 2);
    tick(4);
    chk("c10_retire", 32'(retire_cnt), 10);
    rvfi_valid = 2'b10; rvfi_insn = {32'h00000073, NOP};
    #1;
    chk("c10_env_ok_sys", 32'(env_ok), SYS ? 2'b01 : 2'b11);
    chk("c10_env_fail", 32'(env_fail), 0);
    tick(1);
    chk("c11_env_fail", 32'(env_fail), SYS);
    chk("c11_retire", 32'(retire_cnt), 11);
    rvfi_valid = 2'b01; rvfi_insn = {NOP, 32'h00000001};
    #1;
    chk("c11_env_ok_rvc", 32'(env_ok), SYS ? 2'b10 : 2'b11);
    tick(1);
    rvfi_valid = 2'b11; rvfi_insn = {NOP, NOP}; rvfi_halt = 2'b11;
    #1;
    chk("c12_env_ok_halt", 32'(env_ok), SYS ? 2'b00 : 2'b11);
    chk("c12_retire", 32'(retire_cnt), 12);
    tick(1);
    rvfi_valid = 2'b00; rvfi_halt = 2'b00;
    chk("c13_retire", 32'(retire_cnt), 14);
    tick(7);
    chk("c20_cycle", 32'(cycle), 20);
    chk("c20_check_en", 32'(check_enable), 0);
    chk("c20_phase", 32'(phase), 1);
    tick(1);
    chk("c21_check_en", 32'(check_enable), 1);
    chk("c21_phase", 32'(phase), 2);
    tick(1);
    chk("c22_check_en", 32'(check_enable), 0);
    chk("c22_phase", 32'(phase), 3);
    chk("c22_env_fail", 32'(env_fail), SYS);
    chk("c22_retire", 32'(retire_cnt), 14);
    rvfi_valid = 2'b11;
    tick(120);
    chk("sat_retire_254", 32'(retire_cnt), 254);
    tick(1);
    chk("sat_retire_clamp", 32'(retire_cnt), 255);
    tick(119);
    chk("sat_retire_hold", 32'(retire_cnt), 255);
    chk("sat_cycle", 32'(cycle), 255);
    chk("sat_phase", 32'(phase), 3);
    chk("sat_check_en", 32'(check_enable), 0);
    reset = 1'b1;
    tick(1);
    chk_reset("rst2");
    reset = 1'b0;
    tick(21);
    chk("p2_c21_check_en", 32'(check_enable), 1);
    chk("p2_c21_phase", 32'(phase), 2);
    chk("p2_c21_retire", 32'(retire_cnt), 32);
    chk("p2_c21_env_fail", 32'(env_fail), 0);
    reset = 1'b1;
    tick(1);
    chk_reset("rst_check");
    reset = 1'b0;
    rvfi_valid = 2'b00;
    tick(20);
    chk("p3_c20_check_en", 32'(check_enable), 0);
    tick(1);
    chk("p3_c21_check_en", 32'(check_enable), 1);
    chk("p3_c21_phase", 32'(phase), 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
